// File: rtl/memo_bank_arbiter.sv
// memo_bank_arbiter: round-robin arbiter in front of a small shared register bank.
// Grants one requester at a time, performs the bank access one cycle later,
// and holds the response until the consumer accepts it (IDLE -> ACCESS -> RESP).
module memo_bank_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DEPTH   = 4,
    parameter int HI_W    = 4,
    parameter int LO_W    = 2,
    localparam int EW     = HI_W + LO_W,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*EW-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IW-1:0]         rsp_id,
    output logic                  rsp_we,
    output logic                  rsp_err,
    output logic [EW-1:0]         rsp_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [IW:0]   NUM_REQ_W = (IW+1)'(NUM_REQ);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);
    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);

    state_t         state;
    state_t         state_next;
    logic [IW-1:0]  rr_ptr;
    logic [IW-1:0]  grant_idx;
    logic           grant_valid;
    logic [IW:0]    cand;
    logic           take;

    logic [IW-1:0]  id_q;
    logic           we_q;
    logic [AW-1:0]  addr_q;
    logic [EW-1:0]  wdata_q;
    logic [EW-1:0]  rdata_q;
    logic           err_q;
    logic           in_range;

    logic [EW-1:0]  bank [DEPTH];

    // Addresses in [DEPTH, 2^AW) are not backed by storage and take the error path.
    assign in_range = ({1'b0, addr_q} < DEPTH_W);

    // Round-robin scan starting at rr_ptr; the first valid requester wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (IW+1)'(k);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!grant_valid && req_valid[cand[IW-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[IW-1:0];
            end
        end
    end

    // Next-state and grant decode; the grant is suppressed while reset is held
    // because the capture registers cannot take the request then.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        take       = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid && rst_n) begin
                    req_ready[grant_idx] = 1'b1;
                    take                 = 1'b1;
                    state_next           = ACCESS;
                end
            end
            ACCESS: begin
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the granted request and advance the round-robin pointer past it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            id_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (take) begin
            id_q    <= grant_idx;
            we_q    <= req_we[grant_idx];
            addr_q  <= req_addr[grant_idx*AW +: AW];
            wdata_q <= req_wdata[grant_idx*EW +: EW];
            rr_ptr  <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
        end
    end

    // Response data: write echo, bank read, or zero with error for bad addresses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (state == ACCESS) begin
            if (in_range) begin
                rdata_q <= we_q ? wdata_q : bank[addr_q];
                err_q   <= 1'b0;
            end else begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    // Bank storage; only a write in ACCESS to a backed address commits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
        end else if (state == ACCESS && in_range && we_q) begin
            bank[addr_q] <= wdata_q;
        end
    end

    // Response outputs are only driven while a response is pending.
    assign rsp_valid = (state == RESP);
    assign rsp_id    = rsp_valid ? id_q : '0;
    assign rsp_we    = rsp_valid ? we_q : 1'b0;
    assign rsp_err   = rsp_valid ? err_q : 1'b0;
    assign rsp_rdata = rsp_valid ? rdata_q : '0;

endmodule

// File: tb/tb_memo_bank_arbiter.sv
// Self-checking bench for memo_bank_arbiter (NUM_REQ=4, DEPTH=3, HI_W=4, LO_W=2).
// Expected values come from a behavioural model: an array bank plus a
// round-robin pointer updated by the arbitration rule.
module tb_memo_bank_arbiter;

    localparam int NREQ  = 4;
    localparam int DEPTH = 3;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [3:0]  req_we;
    logic [7:0]  req_addr;
    logic [23:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic        rsp_we;
    logic        rsp_err;
    logic [5:0]  rsp_rdata;

    int tests_run;
    int tests_failed;

    logic [5:0] model_bank [4];
    int         model_rr;

    memo_bank_arbiter #(
        .NUM_REQ (NREQ),
        .DEPTH   (DEPTH),
        .HI_W    (4),
        .LO_W    (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_we    (rsp_we),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runaway guard.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic model_reset();
        for (int i = 0; i < 4; i++) model_bank[i] = '0;
        model_rr = 0;
    endtask

    function automatic int predict_grant(input logic [3:0] mask);
        for (int k = 0; k < NREQ; k++) begin
            if (mask[(model_rr + k) % NREQ]) return (model_rr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [3:0] v);
        if ($countones(v) != 1) return -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_access(input int g, output logic ewe, output logic [5:0] erd, output logic eerr);
        int a;
        ewe = 1'b0; erd = '0; eerr = 1'b0;
        if (g < 0) return;
        a   = int'(req_addr[g*2 +: 2]);
        ewe = req_we[g];
        if (a < DEPTH) begin
            if (ewe) model_bank[a] = req_wdata[g*6 +: 6];
            erd = model_bank[a];
        end else begin
            eerr = 1'b1;
        end
        model_rr = (g + 1) % NREQ;
    endtask

    task automatic drive_req(input int r, input logic we, input int addr, input logic [5:0] wd);
        req_valid[r]       = 1'b1;
        req_we[r]          = we;
        req_addr[r*2 +: 2] = addr[1:0];
        req_wdata[r*6 +: 6] = wd;
    endtask

    // Starts just after the grant sample; returns at the negedge after retirement.
    task automatic await_rsp(input logic drop, output int lat, output logic [1:0] id,
                             output logic w, output logic e, output logic [5:0] rd);
        @(negedge clk);
        if (drop) req_valid = '0;
        lat = -1;
        for (int k = 1; k <= 8; k++) begin
            #1;
            if (rsp_valid === 1'b1) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        id = rsp_id; w = rsp_we; e = rsp_err; rd = rsp_rdata;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'($urandom);
        req_we = 4'($urandom);
        req_addr = 8'($urandom);
        req_wdata = 24'($urandom);
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if (req_ready !== 4'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_req_ready: got %b expected 0000", req_ready);
        end
        tests_run++;
        if ({rsp_valid, rsp_id, rsp_we, rsp_err, rsp_rdata} !== 11'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_rsp: got %h expected 000", {rsp_valid, rsp_id, rsp_we, rsp_err, rsp_rdata});
        end
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_read_after_reset();
        int eg, g, lat;
        logic [1:0] id; logic w, e, ewe, eerr; logic [5:0] rd, erd;
        req_valid = '0;
        drive_req(0, 1'b0, 0, 6'($urandom));
        eg = predict_grant(req_valid);
        #1 g = onehot_idx(req_ready);
        tests_run++;
        if (g !== eg) begin tests_failed++; $display("[TB] FAIL rar_grant: got %0d expected %0d", g, eg); end
        model_access(eg, ewe, erd, eerr);
        await_rsp(1'b1, lat, id, w, e, rd);
        tests_run++;
        if (lat !== 2) begin tests_failed++; $display("[TB] FAIL rar_latency: got %0d expected 2", lat); end
        tests_run++;
        if ({id, w, e, rd} !== {2'(eg), ewe, eerr, erd}) begin
            tests_failed++;
            $display("[TB] FAIL rar_rsp: got %h expected %h", {id, w, e, rd}, {2'(eg), ewe, eerr, erd});
        end
        tests_run++;
        if ({e, rd} !== 7'b0) begin tests_failed++; $display("[TB] FAIL rar_zero: got %h expected 00", {e, rd}); end
    endtask

    task automatic test_write_read();
        int rq [2] = '{0, 3};
        logic wq [2] = '{1'b1, 1'b0};
        int eg, g, lat;
        logic [1:0] id; logic w, e, ewe, eerr; logic [5:0] rd, erd;
        for (int t = 0; t < 2; t++) begin
            req_valid = '0;
            drive_req(rq[t], wq[t], 2, 6'b101010);
            eg = predict_grant(req_valid);
            #1 g = onehot_idx(req_ready);
            tests_run++;
            if (g !== eg) begin tests_failed++; $display("[TB] FAIL wr_grant: got %0d expected %0d", g, eg); end
            model_access(eg, ewe, erd, eerr);
            await_rsp(1'b1, lat, id, w, e, rd);
            tests_run++;
            if (lat !== 2) begin tests_failed++; $display("[TB] FAIL wr_latency: got %0d expected 2", lat); end
            tests_run++;
            if ({id, w, e, rd} !== {2'(eg), ewe, eerr, erd}) begin
                tests_failed++;
                $display("[TB] FAIL wr_rsp: got %h expected %h", {id, w, e, rd}, {2'(eg), ewe, eerr, erd});
            end
        end
    endtask

    task automatic test_round_robin();
        int eg, g, lat;
        logic [1:0] id; logic w, e, ewe, eerr; logic [5:0] rd, erd;
        req_valid = '0;
        for (int r = 0; r < NREQ; r++) drive_req(r, 1'b0, r, 6'($urandom));
        for (int t = 0; t < 5; t++) begin
            eg = predict_grant(req_valid);
            #1 g = onehot_idx(req_ready);
            tests_run++;
            if (g !== eg) begin tests_failed++; $display("[TB] FAIL rr_grant%0d: got %0d expected %0d", t, g, eg); end
            model_access(eg, ewe, erd, eerr);
            await_rsp(1'b0, lat, id, w, e, rd);
            tests_run++;
            if ({id, w, e, rd} !== {2'(eg), ewe, eerr, erd}) begin
                tests_failed++;
                $display("[TB] FAIL rr_rsp%0d: got %h expected %h", t, {id, w, e, rd}, {2'(eg), ewe, eerr, erd});
            end
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        int eg, g, lat;
        logic [1:0] id; logic w, e, ewe, eerr; logic [5:0] rd, erd;
        rsp_ready = 1'b0;
        req_valid = '0;
        drive_req(2, 1'b0, 1, 6'($urandom));
        eg = predict_grant(req_valid);
        #1 g = onehot_idx(req_ready);
        tests_run++;
        if (g !== eg) begin tests_failed++; $display("[TB] FAIL bp_grant: got %0d expected %0d", g, eg); end
        model_access(eg, ewe, erd, eerr);
        @(negedge clk);
        req_valid = '0;
        drive_req(0, 1'($urandom), $urandom_range(0, 2), 6'($urandom));
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            tests_run++;
            if ({rsp_valid, rsp_id, rsp_we, rsp_err, rsp_rdata, req_ready} !== {1'b1, 2'(eg), ewe, eerr, erd, 4'b0}) begin
                tests_failed++;
                $display("[TB] FAIL bp_hold%0d: got %h expected %h", k,
                         {rsp_valid, rsp_id, rsp_we, rsp_err, rsp_rdata, req_ready},
                         {1'b1, 2'(eg), ewe, eerr, erd, 4'b0});
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        eg = predict_grant(req_valid);
        #1 g = onehot_idx(req_ready);
        tests_run++;
        if (g !== eg) begin tests_failed++; $display("[TB] FAIL bp_next_grant: got %0d expected %0d", g, eg); end
        model_access(eg, ewe, erd, eerr);
        await_rsp(1'b1, lat, id, w, e, rd);
        tests_run++;
        if ({id, w, e, rd} !== {2'(eg), ewe, eerr, erd}) begin
            tests_failed++;
            $display("[TB] FAIL bp_next_rsp: got %h expected %h", {id, w, e, rd}, {2'(eg), ewe, eerr, erd});
        end
    endtask

    task automatic test_error();
        int rq [5] = '{1, 2, 0, 3, 1};
        logic wq [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        int aq [5] = '{3, 3, 0, 1, 2};
        int eg, g, lat;
        logic [1:0] id; logic w, e, ewe, eerr; logic [5:0] rd, erd;
        for (int t = 0; t < 5; t++) begin
            req_valid = '0;
            drive_req(rq[t], wq[t], aq[t], 6'($urandom_range(1, 63)));
            eg = predict_grant(req_valid);
            #1 g = onehot_idx(req_ready);
            tests_run++;
            if (g !== eg) begin tests_failed++; $display("[TB] FAIL err_grant%0d: got %0d expected %0d", t, g, eg); end
            model_access(eg, ewe, erd, eerr);
            await_rsp(1'b1, lat, id, w, e, rd);
            tests_run++;
            if ({id, w, e, rd} !== {2'(eg), ewe, eerr, erd}) begin
                tests_failed++;
                $display("[TB] FAIL err_rsp%0d: got %h expected %h", t, {id, w, e, rd}, {2'(eg), ewe, eerr, erd});
            end
        end
    endtask

    task automatic test_reset_mid();
        int eg, g, lat;
        logic [1:0] id; logic w, e, ewe, eerr; logic [5:0] rd, erd;
        // Reset while the write sits in ACCESS: it must not commit.
        req_valid = '0;
        drive_req(1, 1'b1, 1, 6'h3F);
        eg = predict_grant(req_valid);
        #1 g = onehot_idx(req_ready);
        tests_run++;
        if (g !== eg) begin tests_failed++; $display("[TB] FAIL rm_grant: got %0d expected %0d", g, eg); end
        @(negedge clk);
        req_valid = '0;
        drive_req(2, 1'b0, 0, 6'h00);
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({rsp_valid, rsp_id, rsp_we, rsp_err, rsp_rdata, req_ready} !== 15'b0) begin
            tests_failed++;
            $display("[TB] FAIL rm_outputs: got %h expected 0000", {rsp_valid, rsp_id, rsp_we, rsp_err, rsp_rdata, req_ready});
        end
        repeat (2) @(negedge clk);
        req_valid = '0;
        rst_n = 1'b1;
        model_reset();
        drive_req(0, 1'b0, 1, 6'h00);
        eg = predict_grant(req_valid);
        #1 g = onehot_idx(req_ready);
        tests_run++;
        if (g !== eg) begin tests_failed++; $display("[TB] FAIL rm_read_grant: got %0d expected %0d", g, eg); end
        model_access(eg, ewe, erd, eerr);
        await_rsp(1'b1, lat, id, w, e, rd);
        tests_run++;
        if ({id, w, e, rd} !== {2'(eg), ewe, eerr, erd}) begin
            tests_failed++;
            $display("[TB] FAIL rm_read_rsp: got %h expected %h", {id, w, e, rd}, {2'(eg), ewe, eerr, erd});
        end
        // Reset while a response is pending: it is dropped immediately.
        drive_req(3, 1'b0, 1, 6'h00);
        eg = predict_grant(req_valid);
        #1 g = onehot_idx(req_ready);
        tests_run++;
        if (g !== eg) begin tests_failed++; $display("[TB] FAIL rm_resp_grant: got %0d expected %0d", g, eg); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1;
        tests_run++;
        if (rsp_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL rm_resp_pending: got %b expected 1", rsp_valid); end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({rsp_valid, rsp_id, rsp_we, rsp_err, rsp_rdata} !== 11'b0) begin
            tests_failed++;
            $display("[TB] FAIL rm_resp_drop: got %h expected 000", {rsp_valid, rsp_id, rsp_we, rsp_err, rsp_rdata});
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        int eg, g, lat;
        logic [1:0] id; logic w, e, ewe, eerr; logic [5:0] rd, erd;
        logic [3:0] mask;
        for (int t = 0; t < 60; t++) begin
            req_valid = '0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            mask = 4'($urandom_range(1, 15));
            for (int r = 0; r < NREQ; r++) begin
                if (mask[r]) drive_req(r, 1'($urandom), $urandom_range(0, 3), 6'($urandom));
            end
            eg = predict_grant(req_valid);
            #1 g = onehot_idx(req_ready);
            tests_run++;
            if (g !== eg) begin tests_failed++; $display("[TB] FAIL rnd_grant%0d: got %0d expected %0d", t, g, eg); end
            model_access(eg, ewe, erd, eerr);
            await_rsp(1'b1, lat, id, w, e, rd);
            tests_run++;
            if (lat !== 2) begin tests_failed++; $display("[TB] FAIL rnd_latency%0d: got %0d expected 2", t, lat); end
            tests_run++;
            if ({id, w, e, rd} !== {2'(eg), ewe, eerr, erd}) begin
                tests_failed++;
                $display("[TB] FAIL rnd_rsp%0d: got %h expected %h", t, {id, w, e, rd}, {2'(eg), ewe, eerr, erd});
            end
        end
    endtask

    // Scenario sequence.
    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_read_after_reset();
        test_write_read();
        test_round_robin();
        test_backpressure();
        test_error();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
